// File: rtl/mux_alu_src_pkg.sv
// Shared constants for the ALU operand-B source select and its control unit.
package mux_alu_src_pkg;

  // Default datapath width
  localparam int unsigned WIDTH_DEFAULT = 32;

  // ALUSrc encodings, shared with the control unit
  localparam logic ALUSRC_REG = 1'b0;
  localparam logic ALUSRC_IMM = 1'b1;

endpackage : mux_alu_src_pkg

// File: rtl/mux_alu_src_mux2.sv
// Parameterized 2:1 combinational mux, reused by the datapath muxes.
// An unknown select resolves to the i_a input.
module mux2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  // Pick i_b only on a definite 1 select, otherwise i_a
  always_comb begin
    o_y = i_a;
    if (i_sel == 1'b1) begin
      o_y = i_b;
    end
  end

endmodule : mux2

// File: rtl/mux_alu_src.sv
// ALU operand-B source select with a registered copy for the next stage.
module mux_alu_src
  import mux_alu_src_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] imm32,
  input  logic             ALUSrc,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] toAdder,
  output logic [WIDTH-1:0] toAdder_q,
  output logic             out_valid,
  output logic             src_imm_q
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_toAdder_q;
  logic             r_out_valid;
  logic             r_src_imm_q;

  mux2 #(
    .WIDTH (WIDTH)
  ) u_mux2 (
    .i_a   (B),
    .i_b   (imm32),
    .i_sel (ALUSrc == ALUSRC_IMM),
    .o_y   (w_sel)
  );

  assign toAdder = w_sel;

  // Pipeline register: reset, then flush, then stall, then load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_toAdder_q <= '0;
      r_out_valid <= 1'b0;
      r_src_imm_q <= ALUSRC_REG;
    end else if (flush) begin
      r_toAdder_q <= '0;
      r_out_valid <= 1'b0;
      r_src_imm_q <= ALUSRC_REG;
    end else if (!stall) begin
      r_toAdder_q <= w_sel;
      r_out_valid <= in_valid;
      r_src_imm_q <= ALUSrc;
    end
  end

  assign toAdder_q = r_toAdder_q;
  assign out_valid = r_out_valid;
  assign src_imm_q = r_src_imm_q;

endmodule : mux_alu_src

// File: tb/tb_mux_alu_src.sv
// Directed self-checking bench for mux_alu_src.
module tb_mux_alu_src;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] B;
  logic [W-1:0] imm32;
  logic         ALUSrc;
  logic         in_valid;
  logic         stall;
  logic         flush;
  logic [W-1:0] toAdder;
  logic [W-1:0] toAdder_q;
  logic         out_valid;
  logic         src_imm_q;

  int checks;
  int failures;

  mux_alu_src #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .B         (B),
    .imm32     (imm32),
    .ALUSrc    (ALUSrc),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .toAdder   (toAdder),
    .toAdder_q (toAdder_q),
    .out_valid (out_valid),
    .src_imm_q (src_imm_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_sel;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;

    // Combinational select before any edge or reset
    B      = 32'h0000BEEF;
    imm32  = 32'hFFFFDEAD;
    ALUSrc = 1'b0;
    #1;
    check("comb_reg", toAdder, 32'h0000BEEF);
    ALUSrc = 1'b1;
    #0;
    #0;
    check("comb_imm_same_step", toAdder, 32'hFFFFDEAD);

    // Reset for two edges with inputs active
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    check("rst_q", toAdder_q, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_src", {31'b0, src_imm_q}, 32'h0);
    check("rst_comb_follows", toAdder, 32'hFFFFDEAD);

    // Immediate load
    rst_n  = 1'b1;
    imm32  = 32'h12345678;
    ALUSrc = 1'b1;
    tick();
    check("imm_q", toAdder_q, 32'h12345678);
    check("imm_valid", {31'b0, out_valid}, 32'h1);
    check("imm_src", {31'b0, src_imm_q}, 32'h1);

    // Register load then stall for three edges
    B      = 32'hCAFEBABE;
    ALUSrc = 1'b0;
    tick();
    check("reg_q", toAdder_q, 32'hCAFEBABE);
    check("reg_src", {31'b0, src_imm_q}, 32'h0);
    stall = 1'b1;
    B     = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_q", toAdder_q, 32'hCAFEBABE);
      check("stall_valid", {31'b0, out_valid}, 32'h1);
    end
    check("stall_comb", toAdder, 32'h11111111);
    stall = 1'b0;
    tick();
    check("unstall_q", toAdder_q, 32'h11111111);

    // Flush wins over stall
    check("pre_flush_valid", {31'b0, out_valid}, 32'h1);
    ALUSrc = 1'b1;
    tick();
    check("pre_flush_src", {31'b0, src_imm_q}, 32'h1);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    check("flush_q", toAdder_q, 32'h0);
    check("flush_src", {31'b0, src_imm_q}, 32'h0);
    flush = 1'b0;
    stall = 1'b0;

    // Data loads even when not valid
    in_valid = 1'b0;
    ALUSrc   = 1'b0;
    B        = 32'hA5A5_5A5A;
    tick();
    check("novalid_q", toAdder_q, 32'hA5A55A5A);
    check("novalid_valid", {31'b0, out_valid}, 32'h0);

    // Boundary values, alternating select each cycle
    in_valid = 1'b1;
    B        = 32'hFFFFFFFF;
    imm32    = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      ALUSrc  = i[0];
      exp_sel = i[0] ? 32'h00000000 : 32'hFFFFFFFF;
      #1;
      check("bound_comb", toAdder, exp_sel);
      tick();
      check("bound_q", toAdder_q, exp_sel);
      check("bound_src", {31'b0, src_imm_q}, {31'b0, i[0]});
    end

    // Reset mid-operation discards the held operand
    check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    rst_n = 1'b0;
    tick();
    check("midrst_q", toAdder_q, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_alu_src

// File: doc/mux_alu_src.md
# mux_alu_src

ALU operand-B source select for the MIPS execution stage. Chooses between the register-file operand `B` and the sign-extended immediate `imm32` under control of `ALUSrc`. The result drives the ALU/adder B input combinationally. The block also holds a registered copy with valid/stall/flush control so the selected operand can be carried into the next pipeline stage.

## Interface
- `WIDTH`, default 32: datapath width of `B`, `imm32`, `toAdder` and `toAdder_q`.
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst_n`  input  1  reset, synchronous, active-low.
- `B`  input  WIDTH  register operand (rt value).
- `imm32`  input  WIDTH  sign-extended immediate.
- `ALUSrc`  input  1  0 selects `B`, 1 selects `imm32`.
- `in_valid`  input  1  the current inputs form a real instruction.
- `stall`  input  1  hold the registered stage.
- `flush`  input  1  kill the registered stage.
- `toAdder`  output  WIDTH  combinational selected operand.
- `toAdder_q`  output  WIDTH  registered selected operand.
- `out_valid`  output  1  `toAdder_q` holds a valid operand.
- `src_imm_q`  output  1  registered copy of `ALUSrc` for the held operand.

## Operation
- `toAdder` = `imm32` when `ALUSrc`=1, otherwise `B`.
  - Purely combinational; no clock is required.
  - The output is bit-exact, with no extension or truncation.
- If `ALUSrc` is X or Z, the `B` path is selected. Simulation may propagate X.
- Registered stage, evaluated at each `clk` rising edge in this priority order:
  1. `rst_n`=0: `toAdder_q`=0, `out_valid`=0, `src_imm_q`=0.
  2. `flush`=1: `out_valid`=0. `toAdder_q` and `src_imm_q` are cleared to 0.
  3. `stall`=1: all registers hold their values.
  4. Otherwise: `toAdder_q`←`toAdder`, `src_imm_q`←`ALUSrc`, `out_valid`←`in_valid`.
- `flush` takes priority over `stall` when both are asserted.
- The data registers load even when `in_valid`=0. Consumers must qualify the data with `out_valid`.

## Timing
- Combinational path `B`/`imm32`/`ALUSrc` → `toAdder`: zero cycles. It is valid before any clock edge and before reset.
- Registered path: 1-cycle latency from inputs to `toAdder_q`/`out_valid`.
- Reset values: `toAdder_q`=0, `out_valid`=0, `src_imm_q`=0.
  - These apply from the first edge sampled with `rst_n`=0.
  - `toAdder` is unaffected by reset.
- Reset asserted mid-operation discards the held operand on that edge.
- `stall` held for N cycles keeps `toAdder_q` constant for N edges. The first unstalled edge captures the current inputs.

## Structure
- A shared package holds:
  - the `WIDTH` default (32);
  - constants `ALUSRC_REG`=1'b0 and `ALUSRC_IMM`=1'b1, shared with the control unit.
- One natural sub-module, `mux2`: a parameterized 2:1 combinational mux used for the select. It is reused by other datapath muxes.
- The pipeline register is written inline in `mux_alu_src`.

## Test plan
- B=0x0000BEEF, imm32=0xFFFFDEAD, ALUSrc=0, no clock → `toAdder`=0x0000BEEF. Set ALUSrc=1 → `toAdder`=0xFFFFDEAD within the same time step.
- `rst_n`=0 for 2 edges with inputs active → `toAdder_q`=0, `out_valid`=0, `src_imm_q`=0. `toAdder` still follows the select.
- `rst_n`=1, `in_valid`=1, ALUSrc=1, imm32=0x12345678 → after 1 edge, `toAdder_q`=0x12345678, `out_valid`=1, `src_imm_q`=1.
- Stall:
  - Load B=0xCAFEBABE with ALUSrc=0.
  - Assert `stall` for 3 edges while changing B to 0x11111111.
  - Required: `toAdder_q` stays 0xCAFEBABE.
  - Release `stall` → the next edge gives 0x11111111.
- `flush`=1 together with `stall`=1 while `out_valid`=1 → after 1 edge, `out_valid`=0 and `toAdder_q`=0.
- Boundary values: B=0xFFFFFFFF, imm32=0x00000000, toggling ALUSrc each cycle → `toAdder` alternates exactly between the two values, and `toAdder_q` follows one cycle later.
